rr_arbiter: RTL

- Parametrised, registered arbiter and the sequential successor to the team's combinational priority encoder.
- Selects one of NUM_REQ requesters and holds the grant until the winner signals completion.
- Supports fixed priority (highest index wins) or round-robin with a rotating pointer.
- Sits in front of shared resources such as a memory port or a bus master.

---
 rtl/rr_arbiter_pkg.sv | 13 +
 rtl/rr_arbiter_if.sv | 29 ++
 rtl/rr_arbiter_pick.sv | 42 ++++
 rtl/rr_arbiter.sv | 87 ++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the registered round-robin / fixed-priority arbiter.
// Imported by the interface, the picker and the arbiter top.
package arbiter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter_if.sv
// Requester-side bundle of the arbiter: request levels in, registered grant out.
// Handshake: a requester holds request[i] high until it sees grant[i]. It then owns the
// resource until it pulses done for one cycle. The arbiter ignores request changes while
// a grant is held. state mirrors the arbiter FSM so that checkers can observe it.
interface rr_arbiter_if
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0] request;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  state_t             state;

  modport master (
    output request, done,
    input  grant, grant_idx, grant_valid, state
  );

  modport slave (
    input  request, done,
    output grant, grant_idx, grant_valid, state
  );

endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational winner selection: highest set index (fixed) or first set index at or
// above ptr, wrapping to the lowest set index when nothing at or above ptr is requesting.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               mode,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked;
  logic [IDX_W-1:0]   hi_idx;
  logic [IDX_W-1:0]   lo_masked;
  logic [IDX_W-1:0]   lo_full;

  always_comb begin
    mask      = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
    masked    = request & mask;
    hi_idx    = '0;
    lo_masked = '0;
    lo_full   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (request[i]) hi_idx = IDX_W'(i);
    end
    // Scanning downward leaves the lowest set index in place.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (masked[i])  lo_masked = IDX_W'(i);
      if (request[i]) lo_full   = IDX_W'(i);
    end
    any = |request;
    if (mode == MODE_FIXED) winner_idx = hi_idx;
    else if (|masked)       winner_idx = lo_masked;
    else                    winner_idx = lo_full;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Registered arbiter: grants one requester and holds the grant until done, then
// re-arbitrates in the same cycle so back-to-back grants have no idle bubble.
module rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int   NUM_REQ = 4,
  parameter int   IDX_W   = $clog2(NUM_REQ),
  parameter logic MODE    = MODE_RR
) (
  input  logic        clk,
  input  logic        rst,
  rr_arbiter_if.slave bus
);

  state_t             state_q;
  state_t             state_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   winner;
  logic               any;
  logic               arb_en;
  logic               load;
  logic               clear;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .request    (bus.request),
    .ptr        (ptr_q),
    .mode       (MODE),
    .winner_idx (winner),
    .any        (any)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = GRANTED;
      GRANTED: if (bus.done && !any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A stray done while IDLE is harmless: IDLE arbitrates every cycle anyway.
  always_comb begin
    arb_en          = (state_q == IDLE) || bus.done;
    load            = arb_en && any;
    clear           = arb_en && !any;
    bus.grant       = grant_q;
    bus.grant_idx   = idx_q;
    bus.grant_valid = (state_q == GRANTED);
    bus.state       = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else if (load) begin
      grant_q <= NUM_REQ'(1) << winner;
      idx_q   <= winner;
      // Explicit compare so non-power-of-two NUM_REQ wraps to 0.
      ptr_q   <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end else if (clear) begin
      grant_q <= '0;
      idx_q   <= '0;
    end
  end

  a_valid_or : assert property (@(posedge clk) disable iff (rst)
    bus.grant_valid == (|bus.grant));
  a_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.grant));
  a_idx_hit : assert property (@(posedge clk) disable iff (rst)
    bus.grant_valid |-> bus.grant[bus.grant_idx]);
  a_idx_zero : assert property (@(posedge clk) disable iff (rst)
    !bus.grant_valid |-> (bus.grant_idx == '0));

endmodule
